// File: rtl/mcu32x_mem_pkg.sv
// Shared types and default bus widths for the MCU32X memory subsystem.
// Used by the port arbiter, the memory model and the fetch unit.
package mcu32x_mem_pkg;

   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      ACCESS = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single MCU32X memory port between instruction fetch and load/store.
// Runs one transaction at a time, with a starvation guard for fetch and a mem_ready watchdog.
module mem_port_arbiter
   import mcu32x_mem_pkg::*;
#(
   parameter int AW         = AW_DEF,
   parameter int DW         = DW_DEF,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_valid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_valid,
   output logic [DW-1:0] d_rdata,
   output logic          err,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_write_data,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_read_data,
   input  logic          mem_ready
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);

   state_e          state_q, state_d;
   owner_e          owner_q, owner_d;
   logic            we_q, we_d;
   logic [SW-1:0]   starve_cnt_q, starve_cnt_d;
   logic [WW-1:0]   wd_cnt_q, wd_cnt_d;
   logic            if_gnt_q, if_gnt_d;
   logic            if_valid_q, if_valid_d;
   logic [DW-1:0]   if_rdata_q, if_rdata_d;
   logic            d_gnt_q, d_gnt_d;
   logic            d_valid_q, d_valid_d;
   logic [DW-1:0]   d_rdata_q, d_rdata_d;
   logic            err_q, err_d;
   logic [AW-1:0]   mem_address_q, mem_address_d;
   logic [DW-1:0]   mem_write_data_q, mem_write_data_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic            force_i;

   // Fetch has waited through STARVE_MAX data wins and is still asking.
   assign force_i = if_req && (starve_cnt_q == STARVE_LIM);

   always_comb begin
      // NOTE: every _d starts from its _q (pulses from 0) so no branch leaves one unassigned and no latch is inferred.
      state_d          = state_q;
      owner_d          = owner_q;
      we_d             = we_q;
      starve_cnt_d     = starve_cnt_q;
      wd_cnt_d         = wd_cnt_q;
      if_gnt_d         = 1'b0;
      if_valid_d       = 1'b0;
      if_rdata_d       = if_rdata_q;
      d_gnt_d          = 1'b0;
      d_valid_d        = 1'b0;
      d_rdata_d        = d_rdata_q;
      err_d            = 1'b0;
      mem_address_d    = mem_address_q;
      mem_write_data_d = mem_write_data_q;
      mem_read_d       = mem_read_q;
      mem_write_d      = mem_write_q;

      case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               state_d  = GRANT;
               wd_cnt_d = '0;
               if (d_req && !force_i) begin
                  owner_d          = OWN_D;
                  we_d             = d_we;
                  mem_address_d    = d_addr;
                  mem_write_data_d = d_wdata;
                  d_gnt_d          = 1'b1;
                  if (!if_req) begin
                     starve_cnt_d = '0;
                  end else if (starve_cnt_q != STARVE_LIM) begin
                     starve_cnt_d = starve_cnt_q + 1'b1;
                  end
               end else begin
                  owner_d          = OWN_I;
                  we_d             = 1'b0;
                  mem_address_d    = if_addr;
                  mem_write_data_d = '0;
                  if_gnt_d         = 1'b1;
                  starve_cnt_d     = '0;
               end
            end
         end

         GRANT: begin
            mem_read_d  = !we_q;
            mem_write_d = we_q;
            state_d     = ACCESS;
         end

         ACCESS: begin
            if (mem_ready) begin
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = IDLE;
               if (owner_q == OWN_I) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = mem_read_data;
               end else begin
                  d_valid_d = 1'b1;
                  if (!we_q) begin
                     d_rdata_d = mem_read_data;
                  end
               end
            end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
               // Watchdog abort: complete the owner with zero data and flag it.
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               err_d       = 1'b1;
               state_d     = IDLE;
               if (owner_q == OWN_I) begin
                  if_valid_d = 1'b1;
                  if_rdata_d = '0;
               end else begin
                  d_valid_d = 1'b1;
                  d_rdata_d = '0;
               end
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d     = IDLE;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         owner_q          <= OWN_I;
         we_q             <= 1'b0;
         starve_cnt_q     <= '0;
         wd_cnt_q         <= '0;
         if_gnt_q         <= 1'b0;
         if_valid_q       <= 1'b0;
         if_rdata_q       <= '0;
         d_gnt_q          <= 1'b0;
         d_valid_q        <= 1'b0;
         d_rdata_q        <= '0;
         err_q            <= 1'b0;
         mem_address_q    <= '0;
         mem_write_data_q <= '0;
         mem_read_q       <= 1'b0;
         mem_write_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
         state_q          <= state_d;
         owner_q          <= owner_d;
         we_q             <= we_d;
         starve_cnt_q     <= starve_cnt_d;
         wd_cnt_q         <= wd_cnt_d;
         if_gnt_q         <= if_gnt_d;
         if_valid_q       <= if_valid_d;
         if_rdata_q       <= if_rdata_d;
         d_gnt_q          <= d_gnt_d;
         d_valid_q        <= d_valid_d;
         d_rdata_q        <= d_rdata_d;
         err_q            <= err_d;
         mem_address_q    <= mem_address_d;
         mem_write_data_q <= mem_write_data_d;
         mem_read_q       <= mem_read_d;
         mem_write_q      <= mem_write_d;
      end
   end

   assign if_gnt         = if_gnt_q;
   assign if_valid       = if_valid_q;
   assign if_rdata       = if_rdata_q;
   assign d_gnt          = d_gnt_q;
   assign d_valid        = d_valid_q;
   assign d_rdata        = d_rdata_q;
   assign err            = err_q;
   assign mem_address    = mem_address_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;

endmodule
